// File: rtl/cpu_mul_iter_if.sv
// Request/response handshake bundle for the iterative M-stage multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface cpu_mul_iter_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;

    modport master (
        output in_valid, in_mode, in_src1, in_src2, abort, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_mode, in_src1, in_src2, abort, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/cpu_mul_iter.sv
// Iterative DATA_W x DATA_W multiplier: one SLICE_W-bit slice of src1 per cycle,
// followed by a single signed-correction cycle for the high-word modes.
module cpu_mul_iter #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    cpu_mul_iter_if.slave bus
);
    localparam int NSLICES = DATA_W / SLICE_W;
    localparam int ACC_W   = 2 * DATA_W;
    localparam int PROD_W  = DATA_W + SLICE_W;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CORR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_MUL = 2'd0,
        MODE_XUU = 2'd1,
        MODE_XSU = 2'd2,
        MODE_XSS = 2'd3
    } mode_e;

    state_e            state_q;
    mode_e             mode_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]  idx_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q;

    logic [31:0]        shamt;
    logic [SLICE_W-1:0] slice;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   acc_add;
    logic [DATA_W-1:0]  hi_corr;

    always_comb begin
        shamt   = 32'(idx_q) * 32'(SLICE_W);
        slice   = src1_q[shamt +: SLICE_W];
        prod    = PROD_W'(slice) * PROD_W'(src2_q);
        acc_add = ACC_W'(prod) << shamt;

        // Unsigned product corrected to signed: subtract the other operand
        // from the high word for every operand whose sign bit is set.
        hi_corr = acc_q[ACC_W-1:DATA_W];
        if ((mode_q == MODE_XSU || mode_q == MODE_XSS) && src1_q[DATA_W-1])
            hi_corr = hi_corr - src2_q;
        if (mode_q == MODE_XSS && src2_q[DATA_W-1])
            hi_corr = hi_corr - src1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_MUL;
            src1_q       <= '0;
            src2_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (bus.abort) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        src1_q  <= bus.in_src1;
                        src2_q  <= bus.in_src2;
                        mode_q  <= mode_e'(bus.in_mode);
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_q + acc_add;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NSLICES - 1))
                        state_q <= S_CORR;
                end
                S_CORR: begin
                    acc_q        <= {hi_corr, acc_q[DATA_W-1:0]};
                    out_result_q <= (mode_q == MODE_MUL) ? acc_q[DATA_W-1:0] : hi_corr;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
endmodule
